// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants and types for the 4x3 keypad column scanner.
//   - Key code set: 0-9, KEY_STAR ('hA), KEY_HASH ('hB), KEY_NONE (41).
//   - One-hot column drive constants, scan FSM states, frame-result codes.
//   - next_column(): column rotation left -> middle -> right -> left.
package keypad_pkg;

    localparam logic [5:0] KEY_NONE = 6'd41;
    localparam logic [5:0] KEY_STAR = 6'hA;
    localparam logic [5:0] KEY_HASH = 6'hB;

    localparam logic [2:0] COL_LEFT  = 3'b100;
    localparam logic [2:0] COL_MID   = 3'b010;
    localparam logic [2:0] COL_RIGHT = 3'b001;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_e;

    typedef enum logic [1:0] {
        FRAME_NONE   = 2'd0,
        FRAME_SINGLE = 2'd1,
        FRAME_MULTI  = 2'd2
    } frame_res_e;

    // Any illegal pattern falls back to the left column so scanning recovers.
    function automatic logic [2:0] next_column(input logic [2:0] col);
        case (col)
            COL_LEFT: return COL_MID;
            COL_MID:  return COL_RIGHT;
            default:  return COL_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/keypad_row_decode.sv
// keypad_row_decode: combinational key map for one scan slot.
//   columnas [2:0] in  : currently driven column (one-hot)
//   filas    [3:0] in  : row lines, bit3 = top row, 1 = pressed
//   code     [5:0] out : key code when exactly one row is set, else KEY_NONE
//   empty          out : no row set
//   multi          out : more than one row set
// This is the only place the physical key layout is encoded.
module keypad_row_decode
    import keypad_pkg::*;
(
    input  logic [2:0] columnas,
    input  logic [3:0] filas,
    output logic [5:0] code,
    output logic       empty,
    output logic       multi
);

    logic [1:0] row_idx;   // 0 = top row, 3 = bottom row
    logic       one_hot;

    always_comb begin
        row_idx = 2'd0;
        one_hot = 1'b0;
        case (filas)
            4'b1000: begin row_idx = 2'd0; one_hot = 1'b1; end
            4'b0100: begin row_idx = 2'd1; one_hot = 1'b1; end
            4'b0010: begin row_idx = 2'd2; one_hot = 1'b1; end
            4'b0001: begin row_idx = 2'd3; one_hot = 1'b1; end
            default: begin row_idx = 2'd0; one_hot = 1'b0; end
        endcase

        empty = (filas == 4'b0000);
        multi = !empty && !one_hot;

        code = KEY_NONE;
        if (one_hot) begin
            case (columnas)
                COL_LEFT: begin
                    case (row_idx)
                        2'd0:    code = 6'd1;
                        2'd1:    code = 6'd4;
                        2'd2:    code = 6'd7;
                        default: code = KEY_STAR;
                    endcase
                end
                COL_MID: begin
                    case (row_idx)
                        2'd0:    code = 6'd2;
                        2'd1:    code = 6'd5;
                        2'd2:    code = 6'd8;
                        default: code = 6'd0;
                    endcase
                end
                COL_RIGHT: begin
                    case (row_idx)
                        2'd0:    code = 6'd3;
                        2'd1:    code = 6'd6;
                        2'd2:    code = 6'd9;
                        default: code = KEY_HASH;
                    endcase
                end
                default: code = KEY_NONE;
            endcase
        end
    end

endmodule

// File: rtl/keypad_column_scanner.sv
// keypad_column_scanner: rotating one-hot column drive for a 4x3 keypad,
// whole-frame debouncing and a press/hold/release key protocol.
//   clk1k          in  : 1 kHz clock, all logic on rising edge
//   rst            in  : synchronous active-high reset
//   filas    [3:0] in  : row lines (bit3 = top row), 1 = pressed
//   columnas [2:0] out : one-hot column drive, 100 = left, 001 = right
//   num      [5:0] out : accepted key code, KEY_NONE (41) when idle
//   key_valid      out : one-cycle pulse when num takes a newly accepted code
//   key_held       out : high from acceptance until release is accepted
// Optional feature macro: KEYPAD_AUTOREPEAT_EN. When defined, a held key that
// is seen alone every frame re-issues key_valid every REPEAT_FRAMES frames.
module keypad_column_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS      = 4,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int REPEAT_FRAMES   = 50
) (
    input  logic       clk1k,
    input  logic       rst,
    input  logic [3:0] filas,
    output logic [2:0] columnas,
    output logic [5:0] num,
    output logic       key_valid,
    output logic       key_held
);

    if (SCAN_TICKS < 2 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_param_check
        $error("keypad_column_scanner: illegal parameter value");
    end

    localparam int TICK_W = $clog2(SCAN_TICKS);
    localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_FRAMES);

    // Scan / frame accumulator state
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        col_q, col_d;
    logic [1:0]        acc_singles_q, acc_singles_d;  // saturates at 2
    logic [5:0]        acc_code_q, acc_code_d;
    logic              acc_multi_q, acc_multi_d;

    // FSM state
    scan_state_e       state_q, state_d;
    logic [5:0]        cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0]  rel_q, rel_d, rel_inc;

    // Registered outputs
    logic [5:0]        num_q, num_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q, key_held_d;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_DONE = REP_W'(REPEAT_FRAMES);
    logic [REP_W-1:0]  rep_q, rep_d, rep_inc;
`endif

    // Slot decode and frame classification
    logic [5:0]  slot_code;
    logic        slot_empty, slot_multi, slot_single;
    logic        slot_end, frame_end;
    logic [1:0]  singles_now;
    logic        multi_now;
    logic [5:0]  frame_code;
    frame_res_e  frame_res;

    // FSM events handed to the output process
    logic        accept, release_key, repeat_pulse;

    keypad_row_decode u_row_decode (
        .columnas (col_q),
        .filas    (filas),
        .code     (slot_code),
        .empty    (slot_empty),
        .multi    (slot_multi)
    );

    assign slot_single = !slot_empty && !slot_multi;
    assign slot_end    = (tick_q == TICK_LAST);
    assign frame_end   = slot_end && (col_q == COL_RIGHT);

    // Column rotation and per-frame accumulation. The frame result is formed
    // from the accumulator plus the right-column slot sampled this cycle.
    always_comb begin
        tick_d = slot_end ? '0 : tick_q + 1'b1;
        col_d  = slot_end ? next_column(col_q) : col_q;

        singles_now = acc_singles_q;
        if (slot_single && acc_singles_q != 2'd2) begin
            singles_now = acc_singles_q + 2'd1;
        end
        multi_now  = acc_multi_q | slot_multi;
        frame_code = slot_single ? slot_code : acc_code_q;

        if (singles_now == 2'd0 && !multi_now) begin
            frame_res = FRAME_NONE;
        end else if (singles_now == 2'd1 && !multi_now) begin
            frame_res = FRAME_SINGLE;
        end else begin
            frame_res = FRAME_MULTI;
        end

        acc_singles_d = acc_singles_q;
        acc_code_d    = acc_code_q;
        acc_multi_d   = acc_multi_q;
        if (frame_end) begin
            acc_singles_d = 2'd0;
            acc_code_d    = KEY_NONE;
            acc_multi_d   = 1'b0;
        end else if (slot_end) begin
            acc_singles_d = singles_now;
            acc_code_d    = frame_code;
            acc_multi_d   = multi_now;
        end
    end

    // Next-state logic; the FSM only moves at frame end. MULTI frames take
    // the same path as NONE frames.
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        rel_d        = rel_q;
        cnt_inc      = cnt_q + 1'b1;
        rel_inc      = rel_q + 1'b1;
        accept       = 1'b0;
        release_key  = 1'b0;
        repeat_pulse = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d        = rep_q;
        rep_inc      = rep_q + 1'b1;
`endif

        if (frame_end) begin
            case (state_q)
                SCAN: begin
                    if (frame_res == FRAME_SINGLE) begin
                        cand_d = frame_code;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d = HELD;
                            cnt_d   = '0;
                            rel_d   = '0;
                            accept  = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (frame_res == FRAME_SINGLE) begin
                        if (frame_code == cand_q) begin
                            if (cnt_inc == CNT_DONE) begin
                                state_d = HELD;
                                cnt_d   = '0;
                                rel_d   = '0;
                                accept  = 1'b1;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end else begin
                            cand_d = frame_code;
                            cnt_d  = CNT_W'(1);
                        end
                    end else begin
                        state_d = SCAN;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    if (frame_res == FRAME_SINGLE) begin
                        // Any lone key keeps the hold alive; a different key
                        // is not reported until a full release.
                        rel_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (frame_code == cand_q) begin
                            if (rep_inc == REP_DONE) begin
                                rep_d        = '0;
                                repeat_pulse = 1'b1;
                            end else begin
                                rep_d = rep_inc;
                            end
                        end else begin
                            rep_d = '0;
                        end
`endif
                    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d = '0;
`endif
                        if (rel_inc == CNT_DONE) begin
                            state_d     = SCAN;
                            rel_d       = '0;
                            release_key = 1'b1;
                        end else begin
                            rel_d = rel_inc;
                        end
                    end
                end
                default: begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    rel_d   = '0;
                end
            endcase
        end
    end

    // Output logic; outputs are registered so num and key_valid change together.
    always_comb begin
        num_d       = num_q;
        key_held_d  = key_held_q;
        key_valid_d = accept | repeat_pulse;
        if (accept) begin
            num_d      = cand_d;
            key_held_d = 1'b1;
        end else if (release_key) begin
            num_d      = KEY_NONE;
            key_held_d = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk1k) begin
        if (rst) begin
            tick_q        <= '0;
            col_q         <= COL_LEFT;
            acc_singles_q <= 2'd0;
            acc_code_q    <= KEY_NONE;
            acc_multi_q   <= 1'b0;
            state_q       <= SCAN;
            cand_q        <= KEY_NONE;
            cnt_q         <= '0;
            rel_q         <= '0;
            num_q         <= KEY_NONE;
            key_valid_q   <= 1'b0;
            key_held_q    <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q         <= '0;
`endif
        end else begin
            tick_q        <= tick_d;
            col_q         <= col_d;
            acc_singles_q <= acc_singles_d;
            acc_code_q    <= acc_code_d;
            acc_multi_q   <= acc_multi_d;
            state_q       <= state_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            rel_q         <= rel_d;
            num_q         <= num_d;
            key_valid_q   <= key_valid_d;
            key_held_q    <= key_held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q         <= rep_d;
`endif
        end
    end

    assign columnas  = col_q;
    assign num       = num_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
